// File: rtl/riscv_pkg.sv
// Shared core types: FU completion payload, ROB tag width, ROB age compare.
package riscv_pkg;

  localparam int unsigned ReorderBufferTagWidth = 5;
  localparam int unsigned XLEN                  = 32;

  // Completion record broadcast on the CDB; valid qualifies the whole record.
  typedef struct packed {
    logic                             valid;
    logic [ReorderBufferTagWidth-1:0] tag;
    logic [XLEN-1:0]                  value;
    logic                             exception;
  } fu_complete_t;

  // True when tag is younger than ref_tag, with age measured from the ROB head.
  function automatic logic rob_is_younger(
    input logic [ReorderBufferTagWidth-1:0] tag,
    input logic [ReorderBufferTagWidth-1:0] ref_tag,
    input logic [ReorderBufferTagWidth-1:0] head_tag
  );
    logic [ReorderBufferTagWidth-1:0] tag_age;
    logic [ReorderBufferTagWidth-1:0] ref_age;
    tag_age = tag - head_tag;
    ref_age = ref_tag - head_tag;
    return tag_age > ref_age;
  endfunction

endpackage

// File: rtl/fu_cdb_tx_buffer.sv
// Per-FU completion queue feeding one cdb_arbiter input.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_result            FU result, .valid requests a push
//   o_result_ready      queue has room (from state only)
//   o_fu_complete       oldest queued result, all-zero when empty
//   i_grant             arbiter grant for this FU; pops the head
//   i_flush_all         drop everything, including an incoming push
//   i_flush_en          drop entries younger than i_flush_tag
//   i_flush_tag         youngest surviving ROB tag
//   i_rob_head_tag      ROB head, reference for age compare
//   o_count             occupancy
module fu_cdb_tx_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROB_TAG_W = ReorderBufferTagWidth
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  fu_complete_t                 i_result,
  output logic                         o_result_ready,
  output fu_complete_t                 o_fu_complete,
  input  logic                         i_grant,
  input  logic                         i_flush_all,
  input  logic                         i_flush_en,
  input  logic [ROB_TAG_W-1:0]         i_flush_tag,
  input  logic [ROB_TAG_W-1:0]         i_rob_head_tag,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fu_complete_t           entry_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [CNT_W-1:0]       count_q;

  logic                   pop;
  logic                   push;
  logic                   push_keep;
  logic                   run;
  logic [PTR_W-1:0]       head_nxt;
  logic [PTR_W-1:0]       wr_idx;
  logic [PTR_W-1:0]       wr_nxt;
  logic [PTR_W-1:0]       slot_idx;
  logic [PTR_W-1:0]       slot_off;
  logic [CNT_W-1:0]       remain;
  logic [CNT_W-1:0]       surv;
  logic [CNT_W-1:0]       count_nxt;
  logic [DEPTH-1:0]       kill;
  logic [DEPTH-1:0]       live_nxt;

  // Outputs come from registers only.
  assign o_result_ready = count_q < CNT_W'(DEPTH);
  assign o_fu_complete  = (count_q != '0) ? entry_q[rd_ptr_q] : '0;
  assign o_count        = count_q;

  // Next-state: pop first, then flush the remainder, then append the push.
  always_comb begin
    pop       = i_grant && (count_q != '0);
    push      = i_result.valid && o_result_ready;
    head_nxt  = rd_ptr_q + PTR_W'(pop);
    remain    = count_q - CNT_W'(pop);
    kill      = '0;
    surv      = '0;
    run       = 1'b1;
    slot_idx  = '0;
    slot_off  = '0;
    live_nxt  = '0;

    // Kill mask indexed by distance from the post-pop head.
    for (int k = 0; k < DEPTH; k++) begin
      slot_idx = head_nxt + PTR_W'(k);
      kill[k]  = (CNT_W'(k) >= remain) || i_flush_all ||
                 (i_flush_en && rob_is_younger(entry_q[slot_idx].tag, i_flush_tag, i_rob_head_tag));
    end

    // Survivors are the unbroken run of non-killed entries from the head.
    for (int k = 0; k < DEPTH; k++) begin
      if (run && !kill[k]) begin
        surv = surv + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end

    push_keep = push && !i_flush_all &&
                !(i_flush_en && rob_is_younger(i_result.tag, i_flush_tag, i_rob_head_tag));

    // Without a flush the tail is unchanged; with one it is recomputed from the head.
    wr_idx    = (i_flush_en || i_flush_all) ? (head_nxt + PTR_W'(surv)) : wr_ptr_q;
    wr_nxt    = wr_idx + PTR_W'(push_keep);
    count_nxt = surv + CNT_W'(push_keep);

    for (int i = 0; i < DEPTH; i++) begin
      slot_off    = PTR_W'(i) - head_nxt;
      live_nxt[i] = CNT_W'(slot_off) < count_nxt;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= head_nxt;
      wr_ptr_q <= wr_nxt;
      count_q  <= count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].valid <= live_nxt[i];
      end
      if (push_keep) begin
        entry_q[wr_idx]       <= i_result;
        entry_q[wr_idx].valid <= 1'b1;
      end
    end
  end

  // A grant is only meaningful when a result is being presented.
  a_grant_nonempty: assert property (@(posedge i_clk) disable iff (i_rst) !(i_grant && count_q == '0));

endmodule

// File: tb/tb_fu_cdb_tx_buffer.sv
// Bench for fu_cdb_tx_buffer: directed cases plus randomized traffic against a queue model.
module tb_fu_cdb_tx_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int TW    = ReorderBufferTagWidth;

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   value;
  } ent_t;

  logic          clk;
  logic          rst;
  fu_complete_t  res;
  logic          ready;
  fu_complete_t  fc;
  logic          grant;
  logic          flush_all;
  logic          flush_en;
  logic [TW-1:0] flush_tag;
  logic [TW-1:0] rob_head;
  logic [2:0]    cnt;

  int   n_checks;
  int   n_fail;
  ent_t q[$];
  bit   pushed_ok;
  logic [TW-1:0] next_tag;

  fu_cdb_tx_buffer #(.DEPTH(DEPTH), .ROB_TAG_W(TW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_result       (res),
    .o_result_ready (ready),
    .o_fu_complete  (fc),
    .i_grant        (grant),
    .i_flush_all    (flush_all),
    .i_flush_en     (flush_en),
    .i_flush_tag    (flush_tag),
    .i_rob_head_tag (rob_head),
    .o_count        (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  // Age distance from the ROB head, modulo the tag space.
  function automatic int age(input logic [TW-1:0] t, input logic [TW-1:0] h);
    return (int'(t) - int'(h) + (1 << TW)) % (1 << TW);
  endfunction

  function automatic bit younger(input logic [TW-1:0] t);
    return age(t, rob_head) > age(flush_tag, rob_head);
  endfunction

  // Queue semantics applied at each rising edge.
  function automatic void model_step();
    bit   room;
    ent_t keep[$];
    ent_t e;
    pushed_ok = 1'b0;
    if (rst) begin
      q.delete();
      return;
    end
    room = q.size() < DEPTH;
    if (grant && q.size() > 0) void'(q.pop_front());
    if (flush_all) begin
      q.delete();
      return;
    end
    if (flush_en) begin
      foreach (q[i]) if (!younger(q[i].tag)) keep.push_back(q[i]);
      q = keep;
    end
    if (res.valid && room && !(flush_en && younger(res.tag))) begin
      e.tag   = res.tag;
      e.value = res.value;
      q.push_back(e);
      pushed_ok = 1'b1;
    end
  endfunction

  task automatic compare();
    check("count", 64'(cnt), 64'(q.size()));
    check("ready", 64'(ready), 64'(q.size() < DEPTH));
    check("valid", 64'(fc.valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("head_tag", 64'(fc.tag), 64'(q[0].tag));
      check("head_value", 64'(fc.value), 64'(q[0].value));
    end else begin
      check("idle_zero", 64'(fc), 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    rst = 1'b0; grant = 1'b0; flush_all = 1'b0; flush_en = 1'b0;
    res = '0;
  endtask

  task automatic push(input logic [TW-1:0] t);
    res.valid = 1'b1;
    res.tag   = t;
    res.value = $urandom;
    res.exception = 1'($urandom);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    next_tag = '0;
    flush_tag = '0;
    rob_head  = '0;
    idle();

    // Initial reset
    rst = 1'b1; step(); idle();

    // Reset with 3 queued entries
    for (int i = 1; i <= 3; i++) begin push(TW'(i)); step(); end
    idle(); rst = 1'b1; step(); idle();
    check("rst_valid", 64'(fc.valid), 64'd0);
    check("rst_count", 64'(cnt), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);

    // Stalled head, then in-order drain
    for (int i = 5; i <= 7; i++) begin push(TW'(i)); step(); end
    idle(); step(); step();
    check("stall_tag", 64'(fc.tag), 64'd5);
    check("stall_count", 64'(cnt), 64'd3);
    for (int i = 5; i <= 7; i++) begin
      check("drain_order", 64'(fc.tag), 64'(i));
      grant = 1'b1; step();
    end
    idle();

    // Full: drop push, then grant+push at full
    for (int i = 20; i <= 23; i++) begin push(TW'(i)); step(); end
    idle();
    check("full_ready", 64'(ready), 64'd0);
    push(TW'(24)); step();
    check("full_drop_count", 64'(cnt), 64'd4);
    check("full_drop_head", 64'(fc.tag), 64'd20);
    push(TW'(25)); grant = 1'b1; step();
    check("full_gp_count", 64'(cnt), 64'd3);
    check("full_gp_head", 64'(fc.tag), 64'd21);
    idle();
    for (int i = 0; i < 3; i++) begin grant = 1'b1; step(); end
    idle();

    // Partial flush with head granted in the flush cycle
    rob_head = TW'(10);
    for (int i = 10; i <= 13; i++) begin push(TW'(i)); step(); end
    idle(); grant = 1'b1; flush_en = 1'b1; flush_tag = TW'(11); step();
    check("pflush_count", 64'(cnt), 64'd1);
    check("pflush_head", 64'(fc.tag), 64'd11);
    idle(); push(TW'(14)); step();
    idle(); grant = 1'b1; step();
    check("pflush_behind", 64'(fc.tag), 64'd14);
    step(); idle();

    // Flush-all with head granted
    rob_head = TW'(0);
    push(TW'(4)); step(); push(TW'(5)); step();
    idle(); grant = 1'b1; flush_all = 1'b1; step();
    check("fall_valid", 64'(fc.valid), 64'd0);
    idle(); step();
    check("fall_phantom", 64'(fc.valid), 64'd0);

    // Pointer wrap with count swinging 0..4
    next_tag = TW'(1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin push(next_tag); step(); next_tag = next_tag + 1'b1; end
      idle();
      for (int i = 0; i < DEPTH; i++) begin grant = 1'b1; step(); end
      idle();
    end

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      logic [TW-1:0] oldest;
      idle();
      rst       = ($urandom % 100) == 0;
      grant     = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) != 0) push(next_tag);
      oldest    = (q.size() > 0) ? q[0].tag : next_tag;
      rob_head  = oldest - TW'($urandom_range(0, 5));
      flush_all = ($urandom % 40) == 0;
      flush_en  = ($urandom % 8) == 0;
      flush_tag = rob_head + TW'($urandom_range(0, 12));
      step();
      if (pushed_ok) next_tag = next_tag + 1'b1;
      if (flush_en && !flush_all && !rst) next_tag = flush_tag + 1'b1;
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
